mem_to_fifo: RTL and testbench
==============================

Name: mem_to_fifo

Overview:
- Replay-side read engine for the QDR capture buffer.
- Reads a previously written region of QDR SRAM, from MEM_ADDR_LOW up to mem_addr_high-1, in 72-bit words.
- Pushes the words into an internal output FIFO that the downstream packet replay logic drains through a FIFO-style read port.
- Supports N-times or infinite replay, with credit-based flow control so that in-flight reads never overflow the output FIFO.

Parameters:
- FIFO_DATA_WIDTH, 72: output word width; equals 2*MEM_DATA_WIDTH.
- MEM_ADDR_WIDTH, 19: QDR address width.
- MEM_DATA_WIDTH, 36: QDR data half-width.
- MEM_BURST_LENGTH, 2: QDR burst length, 2 or 4. With 4, one command returns 2 words.
- MEM_ADDR_LOW, 0: first word index of the region.
- OFIFO_DEPTH_BITS, 4: output FIFO depth is 2**OFIFO_DEPTH_BITS words.
- REPLAY_CNT_WIDTH, 16: width of the replay counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fifo_rd_en  in  1  downstream pop; ignored when fifo_empty=1
- fifo_data  out  FIFO_DATA_WIDTH  head word, first-word-fall-through, {mem_qrh, mem_qrl}
- fifo_empty  out  1  output FIFO empty
- mem_ad_r_n  out  1  read command strobe, active-low
- mem_rd_full  in  1  memory controller command queue full
- mem_ad_rd  out  MEM_ADDR_WIDTH  read address
- mem_qrl  in  MEM_DATA_WIDTH  read data, low half
- mem_qrh  in  MEM_DATA_WIDTH  read data, high half
- mem_qr_valid  in  1  one read data word valid
- mem_addr_high  in  MEM_ADDR_WIDTH+1  exclusive end word index; equals the writer's final word count
- replay_cnt  in  REPLAY_CNT_WIDTH  number of passes; 0 means infinite
- start  in  1  single-cycle start pulse
- sw_rst  in  1  software reset, same effect as rst
- cal_done  in  1  QDR calibration done
- busy  out  1  high in READ and DRAIN
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset (rst or sw_rst):
  - state=IDLE; mem_ad_r_n=1; mem_ad_rd=MEM_ADDR_LOW.
  - busy=0; done=0; fifo_empty=1.
  - outstanding=0; word index=MEM_ADDR_LOW; passes_left=0.
  - Output FIFO flushed. Read data arriving after reset is discarded.
  - Reset in mid-operation aborts immediately; no done pulse.
- cal_done is registered once (cal_done_r). Commands are issued only while cal_done_r=1.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On start && cal_done_r: load word index=MEM_ADDR_LOW and passes_left=replay_cnt.
  - If mem_addr_high<=MEM_ADDR_LOW, go to DONE. Otherwise go to READ.
  - start outside IDLE is ignored.
- READ, command issue:
  - A command is issued in a cycle when !mem_rd_full && cal_done_r && credit_ok.
  - credit_ok: outstanding + ofifo_count + W <= depth, where W = MEM_BURST_LENGTH/2 words per command.
- READ, per issued command:
  - mem_ad_r_n=0 registered the next cycle. mem_ad_rd = word index for burst 2, or word index >> 1 for burst 4.
  - outstanding += W. Word index += W.
- READ, end of region:
  - If the issued command covers word mem_addr_high-1: when passes_left==1, go to DRAIN.
  - Otherwise wrap the word index to MEM_ADDR_LOW. Decrement passes_left only when it is nonzero; 0 stays infinite.
- Odd region with burst 4: the last command still returns 2 words. The final extra word is pushed. Software sizes regions even.
- mem_qr_valid:
  - Pushes {mem_qrh, mem_qrl} into the output FIFO and decrements outstanding by 1.
  - Issue and return in the same cycle net correctly: outstanding += W-1.
- The output FIFO can never overflow, by the credit rule. A push into a full FIFO is a design error; assert it in simulation.
- DRAIN: wait until outstanding==0, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. The FIFO contents remain poppable.
- Output FIFO:
  - First-word-fall-through; push-to-empty-deassert latency is 1 cycle.
  - Simultaneous push and pop are allowed when full or empty.
- Infinite replay exits only via sw_rst or rst.

Test Plan:
- Burst 2, mem_addr_high=8, replay_cnt=1, fifo_rd_en held 1, 4-cycle memory latency -> 8 commands at addresses 0..7; 8 words popped in address order; done pulses once; busy falls.
- replay_cnt=3, mem_addr_high=4 -> 12 words delivered, address sequence 0,1,2,3 repeated three times; exactly one done pulse.
- fifo_rd_en=0, depth 16, latency 4 -> no more than 16 commands issued; fifo_empty=0 with 16 words held; popping resumes issue with no word lost or duplicated.
- mem_rd_full pulsed 1 every other cycle -> no command is issued while it is high; address sequence stays contiguous.
- Burst 4, mem_addr_high=8 -> 4 commands at mem_ad_rd 0,1,2,3; 8 words out.
- Boundary and reset cases:
  - mem_addr_high=0 -> done pulses 2 cycles after start; no commands.
  - sw_rst mid-READ -> IDLE, fifo_empty=1, no done pulse.
  - start while cal_done=0 -> ignored.

Source files
------------

// File: rtl/mem_to_fifo.sv
// Replay-side read engine: streams a QDR region (optionally N times or forever)
// into a small first-word-fall-through FIFO, with read credits sized to that FIFO.
module mem_to_fifo #(
    parameter int FIFO_DATA_WIDTH  = 72,
    parameter int MEM_ADDR_WIDTH   = 19,
    parameter int MEM_DATA_WIDTH   = 36,
    parameter int MEM_BURST_LENGTH = 2,
    parameter int MEM_ADDR_LOW     = 0,
    parameter int OFIFO_DEPTH_BITS = 4,
    parameter int REPLAY_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fifo_rd_en,
    output logic [FIFO_DATA_WIDTH-1:0]  fifo_data,
    output logic                        fifo_empty,
    output logic                        mem_ad_r_n,
    input  logic                        mem_rd_full,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_ad_rd,
    input  logic [MEM_DATA_WIDTH-1:0]   mem_qrl,
    input  logic [MEM_DATA_WIDTH-1:0]   mem_qrh,
    input  logic                        mem_qr_valid,
    input  logic [MEM_ADDR_WIDTH:0]     mem_addr_high,
    input  logic [REPLAY_CNT_WIDTH-1:0] replay_cnt,
    input  logic                        start,
    input  logic                        sw_rst,
    input  logic                        cal_done,
    output logic                        busy,
    output logic                        done
);
    localparam int W     = MEM_BURST_LENGTH / 2;
    localparam int DEPTH = 1 << OFIFO_DEPTH_BITS;
    localparam int CW    = OFIFO_DEPTH_BITS + 1;
    localparam int AW    = MEM_ADDR_WIDTH + 2;
    localparam int SW    = CW + 2;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    logic srst;
    assign srst = rst | sw_rst;

    state_t                      state_q, state_d;
    logic [AW-1:0]               idx_q, idx_d;
    logic [REPLAY_CNT_WIDTH-1:0] passes_q, passes_d;
    logic [CW-1:0]               outst_q, outst_d;
    logic                        cmd_n_q, cmd_n_d;
    logic [MEM_ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic                        done_q, done_d;
    logic                        cal_done_q;
    logic                        issue;

    logic [FIFO_DATA_WIDTH-1:0]  fifo_mem [DEPTH];
    logic [OFIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]               count_q;
    logic                        push, pop, credit_ok;
    logic [SW-1:0]               credit_sum;
    logic [AW-1:0]               high_ext;

    assign high_ext   = AW'(mem_addr_high);
    // Returns are only accepted against outstanding reads, so stale data after a reset is dropped.
    assign push       = mem_qr_valid && (outst_q != '0);
    assign pop        = fifo_rd_en && (count_q != '0);
    assign credit_sum = SW'(outst_q) + SW'(count_q) + SW'(W);
    assign credit_ok  = credit_sum <= SW'(DEPTH);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        passes_d   = passes_q;
        cmd_n_d    = 1'b1;
        cmd_addr_d = cmd_addr_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && cal_done_q) begin
                    idx_d    = AW'(MEM_ADDR_LOW);
                    passes_d = replay_cnt;
                    state_d  = (high_ext <= AW'(MEM_ADDR_LOW)) ? DONE : READ;
                end
            end
            READ: begin
                if (!mem_rd_full && cal_done_q && credit_ok) begin
                    issue      = 1'b1;
                    cmd_n_d    = 1'b0;
                    // Burst-4 commands address word pairs.
                    cmd_addr_d = MEM_ADDR_WIDTH'(idx_q >> (W - 1));
                    if (idx_q + AW'(W) >= high_ext) begin
                        if (passes_q == REPLAY_CNT_WIDTH'(1)) begin
                            state_d = DRAIN;
                        end else begin
                            idx_d = AW'(MEM_ADDR_LOW);
                            if (passes_q != '0) passes_d = passes_q - 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + AW'(W);
                    end
                end
            end
            DRAIN: begin
                if (outst_q == '0) state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        if (issue) outst_d = outst_d + CW'(W);
        if (push)  outst_d = outst_d - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cal_done_q <= 1'b0;
        else     cal_done_q <= cal_done;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= IDLE;
            idx_q      <= AW'(MEM_ADDR_LOW);
            passes_q   <= '0;
            outst_q    <= '0;
            cmd_n_q    <= 1'b1;
            cmd_addr_q <= MEM_ADDR_WIDTH'(MEM_ADDR_LOW);
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            passes_q   <= passes_d;
            outst_q    <= outst_d;
            cmd_n_q    <= cmd_n_d;
            cmd_addr_q <= cmd_addr_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {mem_qrh, mem_qrl};
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!srst) assert (!(push && !pop && (count_q == CW'(DEPTH))));
    end

    assign fifo_data  = fifo_mem[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign mem_ad_r_n = cmd_n_q;
    assign mem_ad_rd  = cmd_addr_q;
    assign busy       = (state_q == READ) || (state_q == DRAIN);
    assign done       = done_q;

endmodule

// File: tb/tb_mem_to_fifo.sv
// Scoreboarded bench for mem_to_fifo: burst-2 and burst-4 instances share one
// QDR latency model; expected commands and words are queued at stimulus time.
module tb_mem_to_fifo;
    localparam int AWID = 19;
    localparam int DW   = 36;
    localparam int FW   = 72;
    localparam int LAT  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sw_rst, cal_done, start, fifo_rd_en, mem_rd_full, mem_qr_valid, sel4, toggle_en;
    logic [DW-1:0]   mem_qrl, mem_qrh;
    logic [AWID:0]   mem_addr_high;
    logic [15:0]     replay_cnt;
    logic            start2, start4;
    logic [FW-1:0]   fd2, fd4, a_fd;
    logic            fe2, fe4, rn2, rn4, busy2, busy4, done2, done4;
    logic            a_fe, a_rn, a_busy, a_done;
    logic [AWID-1:0] ad2, ad4, a_ad;

    assign start2 = start & ~sel4;
    assign start4 = start & sel4;
    assign a_fd   = sel4 ? fd4   : fd2;
    assign a_fe   = sel4 ? fe4   : fe2;
    assign a_rn   = sel4 ? rn4   : rn2;
    assign a_ad   = sel4 ? ad4   : ad2;
    assign a_busy = sel4 ? busy4 : busy2;
    assign a_done = sel4 ? done4 : done2;

    mem_to_fifo u_dut (
        .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_data(fd2), .fifo_empty(fe2),
        .mem_ad_r_n(rn2), .mem_rd_full(mem_rd_full), .mem_ad_rd(ad2), .mem_qrl(mem_qrl),
        .mem_qrh(mem_qrh), .mem_qr_valid(mem_qr_valid), .mem_addr_high(mem_addr_high),
        .replay_cnt(replay_cnt), .start(start2), .sw_rst(sw_rst), .cal_done(cal_done),
        .busy(busy2), .done(done2)
    );

    mem_to_fifo #(.MEM_BURST_LENGTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_data(fd4), .fifo_empty(fe4),
        .mem_ad_r_n(rn4), .mem_rd_full(mem_rd_full), .mem_ad_rd(ad4), .mem_qrl(mem_qrl),
        .mem_qrh(mem_qrh), .mem_qr_valid(mem_qr_valid), .mem_addr_high(mem_addr_high),
        .replay_cnt(replay_cnt), .start(start4), .sw_rst(sw_rst), .cal_done(cal_done),
        .busy(busy4), .done(done4)
    );

    int checks = 0;
    int failures = 0;
    int cmd_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    logic full_prev = 1'b0;
    logic [FW-1:0] exp_q[$];
    int            cmd_q[$];

    typedef struct { int t; int w; } ret_t;
    ret_t ret_q[$];

    function automatic logic [FW-1:0] word_f(input int w);
        logic [DW-1:0] h, l;
        h = DW'(w) + DW'(256);
        l = DW'(w) ^ DW'('hABC);
        return {h, l};
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // QDR model: fixed latency, one word per cycle, burst-4 commands return two words.
    initial begin
        mem_qr_valid = 1'b0;
        mem_qrl = '0;
        mem_qrh = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (a_rn == 1'b0) begin
                for (int k = 0; k < (sel4 ? 2 : 1); k++)
                    ret_q.push_back('{cyc + LAT + k, sel4 ? 2 * int'(a_ad) + k : int'(a_ad)});
            end
            #1;
            if (ret_q.size() > 0 && ret_q[0].t <= cyc) begin
                ret_t r;
                r = ret_q.pop_front();
                mem_qr_valid = 1'b1;
                {mem_qrh, mem_qrl} = word_f(r.w);
            end else begin
                mem_qr_valid = 1'b0;
            end
        end
    end

    initial begin
        mem_rd_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_rd_full = toggle_en ? ~mem_rd_full : 1'b0;
        end
    end

    // Monitor: pops, commands and done pulses are compared against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_rd_en && !a_fe) begin
                if (exp_q.size() == 0) chk(1'b0, "pop_unexpected", a_fd, '0);
                else begin
                    logic [FW-1:0] e;
                    e = exp_q.pop_front();
                    chk(a_fd == e, "pop_data", a_fd, e);
                end
            end
            if (!a_rn) begin
                cmd_cnt++;
                chk(!full_prev, "cmd_while_full", 72'(full_prev), 72'd0);
                if (cmd_q.size() == 0) chk(1'b0, "cmd_unexpected", 72'(a_ad), '0);
                else begin
                    int ea;
                    ea = cmd_q.pop_front();
                    chk(int'(a_ad) == ea, "cmd_addr", 72'(a_ad), 72'(ea));
                end
            end
            if (a_done) done_cnt++;
            full_prev = mem_rd_full;
        end
    end

    task automatic run_and_finish(input int d0, input string nm);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 600) begin tick(1); n++; end
        chk(done_cnt != d0, {nm, "_done_seen"}, 72'(done_cnt - d0), 72'd1);
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin tick(1); n++; end
        chk(exp_q.size() == 0, {nm, "_words_left"}, 72'(exp_q.size()), 72'd0);
        tick(3);
        chk(done_cnt - d0 == 1, {nm, "_done_pulses"}, 72'(done_cnt - d0), 72'd1);
        chk(a_busy == 1'b0, {nm, "_busy_low"}, 72'(a_busy), 72'd0);
        chk(cmd_q.size() == 0, {nm, "_cmds_left"}, 72'(cmd_q.size()), 72'd0);
        $display("test %s: words and commands consumed, done_pulses=%0d", nm, done_cnt - d0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        int d0, c0, c1;
        rst = 1'b1; sw_rst = 1'b0; cal_done = 1'b1; start = 1'b0; fifo_rd_en = 1'b0;
        sel4 = 1'b0; toggle_en = 1'b0; mem_addr_high = '0; replay_cnt = '0;
        tick(3);
        rst = 1'b0;
        tick(2);
        chk(a_fe == 1'b1, "rst_empty", 72'(a_fe), 72'd1);
        chk(a_busy == 1'b0, "rst_busy", 72'(a_busy), 72'd0);
        chk(a_done == 1'b0, "rst_done", 72'(a_done), 72'd0);
        chk(a_rn == 1'b1, "rst_r_n", 72'(a_rn), 72'd1);
        chk(a_ad == '0, "rst_addr", 72'(a_ad), 72'd0);

        // Single pass, 8 words
        fifo_rd_en = 1'b1; mem_addr_high = 20'd8; replay_cnt = 16'd1;
        for (int i = 0; i < 8; i++) begin cmd_q.push_back(i); exp_q.push_back(word_f(i)); end
        d0 = done_cnt; pulse_start(); run_and_finish(d0, "single");

        // Three passes over 4 words
        mem_addr_high = 20'd4; replay_cnt = 16'd3;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 4; i++) begin cmd_q.push_back(i); exp_q.push_back(word_f(i)); end
        d0 = done_cnt; pulse_start(); run_and_finish(d0, "replay3");

        // Stalled consumer: credits cap issue at the FIFO depth
        fifo_rd_en = 1'b0; mem_addr_high = 20'd32; replay_cnt = 16'd1;
        for (int i = 0; i < 32; i++) begin cmd_q.push_back(i); exp_q.push_back(word_f(i)); end
        d0 = done_cnt; c0 = cmd_cnt; pulse_start();
        tick(60);
        chk(cmd_cnt - c0 == 16, "credit_limit", 72'(cmd_cnt - c0), 72'd16);
        chk(a_fe == 1'b0, "fifo_held", 72'(a_fe), 72'd0);
        fifo_rd_en = 1'b1;
        run_and_finish(d0, "credit");

        // Command queue full every other cycle
        toggle_en = 1'b1; mem_addr_high = 20'd8; replay_cnt = 16'd1;
        for (int i = 0; i < 8; i++) begin cmd_q.push_back(i); exp_q.push_back(word_f(i)); end
        d0 = done_cnt; pulse_start(); run_and_finish(d0, "rdfull");
        toggle_en = 1'b0;
        tick(2);

        // Burst 4: 4 commands at word-pair addresses
        sel4 = 1'b1; mem_addr_high = 20'd8; replay_cnt = 16'd1;
        for (int i = 0; i < 4; i++) cmd_q.push_back(i);
        for (int i = 0; i < 8; i++) exp_q.push_back(word_f(i));
        d0 = done_cnt; pulse_start(); run_and_finish(d0, "burst4");
        sel4 = 1'b0;
        tick(2);

        // Empty region: done two cycles after start, no commands
        mem_addr_high = 20'd0; d0 = done_cnt; c0 = cmd_cnt;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk(a_done == 1'b0, "empty_done_early", 72'(a_done), 72'd0);
        tick(1);
        chk(a_done == 1'b1, "empty_done_at2", 72'(a_done), 72'd1);
        tick(5);
        chk(cmd_cnt == c0, "empty_no_cmds", 72'(cmd_cnt - c0), 72'd0);
        chk(done_cnt - d0 == 1, "empty_done_pulses", 72'(done_cnt - d0), 72'd1);
        $display("test empty: done_pulses=%0d cmds=%0d", done_cnt - d0, cmd_cnt - c0);

        // sw_rst during an infinite replay
        fifo_rd_en = 1'b0; mem_addr_high = 20'd32; replay_cnt = 16'd0;
        for (int i = 0; i < 16; i++) cmd_q.push_back(i);
        d0 = done_cnt; pulse_start();
        tick(10);
        chk(a_busy == 1'b1, "swrst_busy_before", 72'(a_busy), 72'd1);
        sw_rst = 1'b1;
        tick(1);
        sw_rst = 1'b0;
        c1 = cmd_cnt;
        chk(a_fe == 1'b1, "swrst_empty", 72'(a_fe), 72'd1);
        chk(a_busy == 1'b0, "swrst_busy", 72'(a_busy), 72'd0);
        tick(20);
        chk(a_fe == 1'b1, "swrst_stale_dropped", 72'(a_fe), 72'd1);
        chk(cmd_cnt == c1, "swrst_no_cmds", 72'(cmd_cnt - c1), 72'd0);
        chk(done_cnt == d0, "swrst_no_done", 72'(done_cnt - d0), 72'd0);
        cmd_q.delete();
        $display("test swrst: aborted, empty=%0d", a_fe);

        // start without calibration is ignored
        cal_done = 1'b0;
        tick(3);
        mem_addr_high = 20'd8; replay_cnt = 16'd1; d0 = done_cnt; c0 = cmd_cnt;
        pulse_start();
        tick(20);
        chk(a_busy == 1'b0, "nocal_busy", 72'(a_busy), 72'd0);
        chk(cmd_cnt == c0, "nocal_cmds", 72'(cmd_cnt - c0), 72'd0);
        chk(done_cnt == d0, "nocal_done", 72'(done_cnt - d0), 72'd0);
        $display("test nocal: start ignored");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
